biquad_mac_scheduler: RTL and testbench

Time-multiplexed biquad IIR engine for the channel strip. One shared 16x16 multiplier-accumulator evaluates y = b0*x0 + b1*x1 + b2*x2 + a1*y1 + a2*y2, one tap per cycle, for up to CH independent audio channels. The block sequences the taps, keeps the per-channel history, and owns a double-buffered coefficient bank. It sits between the sample source and the downstream gain stage, with valid/ready handshakes on both sides.

---
 rtl/biquad_mac_scheduler_if.sv | 24 ++
 rtl/biquad_mac_scheduler.sv | 175 +++++++++++++++++
 tb/tb_biquad_mac_scheduler.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/biquad_mac_scheduler_if.sv
// Sample-in / result-out handshake bundle for the shared biquad engine.
// master drives samples and accepts results; slave is the engine.
interface biquad_mac_scheduler_if #(
  parameter int CHW = 1
);
  logic           in_valid;
  logic           in_ready;
  logic [15:0]    in_data;
  logic [CHW-1:0] in_ch;
  logic           out_valid;
  logic           out_ready;
  logic [15:0]    out_data;
  logic [CHW-1:0] out_ch;

  modport master (
    output in_valid, in_data, in_ch, out_ready,
    input  in_ready, out_valid, out_data, out_ch
  );

  modport slave (
    input  in_valid, in_data, in_ch, out_ready,
    output in_ready, out_valid, out_data, out_ch
  );
endinterface

// File: rtl/biquad_mac_scheduler.sv
// Time-multiplexed biquad IIR: one 16x16 MAC, one tap per cycle,
// per-channel x/y history and a double-buffered coefficient bank.
module biquad_mac_scheduler #(
  parameter int CH   = 2,
  parameter int CHW  = 1,
  parameter int ACCW = 40,
  parameter int FRAC = 10
) (
  input  logic                 clk,
  input  logic                 reset_n,
  biquad_mac_scheduler_if.slave bus,
  input  logic                 coef_we,
  input  logic [2:0]           coef_addr,
  input  logic [15:0]          coef_wdata,
  input  logic                 coef_commit,
  output logic                 sat,
  output logic                 ch_err
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MAC  = 2'd1;
  localparam logic [1:0] S_OUT  = 2'd2;

  // {a2, a1, b2, b1, b0}
  localparam logic [4:0][15:0] DEF_BANK = {
    16'hFC12, 16'd2030, 16'd1015, 16'd2030, 16'd1015
  };
  localparam logic [CHW:0] CH_L = CH[CHW:0];
  localparam logic signed [ACCW-1:0] SAT_HI = ACCW'(32767);
  localparam logic signed [ACCW-1:0] SAT_LO = ACCW'(-32768);

  logic [1:0]             state;
  logic [2:0]             tap;
  logic signed [15:0]     x0;
  logic [CHW-1:0]         ch_l;
  logic signed [ACCW-1:0] acc;
  logic signed [ACCW-1:0] acc_nx;
  logic signed [ACCW-1:0] r;
  logic signed [15:0]     coef;
  logic signed [15:0]     op;
  logic signed [31:0]     prod;
  logic signed [15:0]     y_sat;
  logic                   clip;
  logic                   bad_ch;
  logic                   pend;
  logic [4:0][15:0]       act;
  logic [4:0][15:0]       shd;
  logic [4:0][15:0]       shd_nx;

  logic signed [15:0] x1_m [CH];
  logic signed [15:0] x2_m [CH];
  logic signed [15:0] y1_m [CH];
  logic signed [15:0] y2_m [CH];

  logic           out_valid_q;
  logic [15:0]    out_data_q;
  logic [CHW-1:0] out_ch_q;

  assign bus.in_ready  = (state == S_IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_ch    = out_ch_q;

  assign bad_ch = ({1'b0, bus.in_ch} >= CH_L);

  always_comb begin
    shd_nx = shd;
    if (coef_we && (coef_addr < 3'd5))
      shd_nx[coef_addr] = coef_wdata;
  end

  always_comb begin
    coef = '0;
    op   = '0;
    case (tap)
      3'd0: begin coef = act[0]; op = x0;         end
      3'd1: begin coef = act[1]; op = x1_m[ch_l]; end
      3'd2: begin coef = act[2]; op = x2_m[ch_l]; end
      3'd3: begin coef = act[3]; op = y1_m[ch_l]; end
      3'd4: begin coef = act[4]; op = y2_m[ch_l]; end
      default: ;
    endcase
  end

  assign prod = $signed({{16{coef[15]}}, coef})
              * $signed({{16{op[15]}}, op});
  assign acc_nx = acc + {{(ACCW-32){prod[31]}}, prod};
  assign r = acc >>> FRAC;

  always_comb begin
    clip  = 1'b0;
    y_sat = r[15:0];
    if (r > SAT_HI) begin
      clip  = 1'b1;
      y_sat = 16'sh7FFF;
    end else if (r < SAT_LO) begin
      clip  = 1'b1;
      y_sat = 16'sh8000;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      tap         <= '0;
      x0          <= '0;
      ch_l        <= '0;
      acc         <= '0;
      pend        <= 1'b0;
      act         <= DEF_BANK;
      shd         <= DEF_BANK;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
      sat         <= 1'b0;
      ch_err      <= 1'b0;
      for (int i = 0; i < CH; i++) begin
        x1_m[i] <= '0;
        x2_m[i] <= '0;
        y1_m[i] <= '0;
        y2_m[i] <= '0;
      end
    end else begin
      sat    <= 1'b0;
      ch_err <= 1'b0;
      shd    <= shd_nx;
      // copy sees a same-edge shadow write; sample taken now uses it
      if ((state == S_IDLE) && (pend || coef_commit)) begin
        act  <= shd_nx;
        pend <= 1'b0;
      end else if (coef_commit) begin
        pend <= 1'b1;
      end
      unique case (state)
        S_IDLE: begin
          if (bus.in_valid) begin
            if (bad_ch) begin
              ch_err <= 1'b1;
            end else begin
              x0    <= bus.in_data;
              ch_l  <= bus.in_ch;
              acc   <= '0;
              tap   <= '0;
              state <= S_MAC;
            end
          end
        end
        S_MAC: begin
          if (tap == 3'd5) begin
            out_data_q   <= y_sat;
            out_ch_q     <= ch_l;
            out_valid_q  <= 1'b1;
            sat          <= clip;
            x2_m[ch_l]   <= x1_m[ch_l];
            x1_m[ch_l]   <= x0;
            y2_m[ch_l]   <= y1_m[ch_l];
            y1_m[ch_l]   <= y_sat;
            state        <= S_OUT;
          end else begin
            acc <= acc_nx;
            tap <= tap + 3'd1;
          end
        end
        S_OUT: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            state       <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_biquad_mac_scheduler.sv
// Scoreboard bench for biquad_mac_scheduler: directed samples push
// hand-computed results; a negedge monitor pops and compares.
module tb_biquad_mac_scheduler;
  localparam int CH  = 3;
  localparam int CHW = 2;

  typedef struct packed {
    logic [15:0]    d;
    logic [CHW-1:0] ch;
    logic           s;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        coef_we = 1'b0;
  logic [2:0]  coef_addr = '0;
  logic [15:0] coef_wdata = '0;
  logic        coef_commit = 1'b0;
  logic        sat;
  logic        ch_err;

  int checks = 0;
  int errors = 0;
  exp_t q[$];

  always #5 clk = ~clk;

  biquad_mac_scheduler_if #(.CHW(CHW)) bus ();

  biquad_mac_scheduler #(
    .CH(CH), .CHW(CHW), .ACCW(40), .FRAC(10)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus),
    .coef_we(coef_we),
    .coef_addr(coef_addr),
    .coef_wdata(coef_wdata),
    .coef_commit(coef_commit),
    .sat(sat),
    .ch_err(ch_err)
  );

  task automatic chk(input string nm, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", nm, got, exp);
    end
  endtask

  task automatic expect_out(input int ch, input int data, input bit s);
    exp_t e;
    e.d  = data[15:0];
    e.ch = ch[CHW-1:0];
    e.s  = s;
    q.push_back(e);
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    @(negedge clk);
    while (!bus.in_ready && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) begin
      checks++;
      errors++;
      $display("FAIL wait_ready timeout in_ready=%0b", bus.in_ready);
    end
  endtask

  task automatic issue(input int ch, input int data);
    wait_ready();
    bus.in_valid = 1'b1;
    bus.in_ch    = ch[CHW-1:0];
    bus.in_data  = data[15:0];
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
  endtask

  task automatic lat_check();
    int k;
    k = 0;
    do begin
      @(posedge clk);
      #1 k++;
    end while (!bus.out_valid && k < 20);
    chk("latency", k, 6);
  endtask

  task automatic wcoef(input int a, input int d, input bit c);
    @(negedge clk);
    coef_we     = 1'b1;
    coef_addr   = a[2:0];
    coef_wdata  = d[15:0];
    coef_commit = c;
    @(posedge clk);
    #1;
    coef_we     = 1'b0;
    coef_commit = 1'b0;
  endtask

  // monitor: compare on the first cycle of every presented result
  initial begin
    exp_t e;
    logic prev_v;
    prev_v = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        prev_v = 1'b0;
      end else begin
        if (bus.out_valid && !prev_v) begin
          checks++;
          if (q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_out data=%0d ch=%0d",
                     $signed(bus.out_data), bus.out_ch);
          end else begin
            e = q.pop_front();
            if (bus.out_data !== e.d || bus.out_ch !== e.ch ||
                sat !== e.s) begin
              errors++;
              $display("FAIL result got=%0d/ch%0d/sat%0b exp=%0d/ch%0d/sat%0b",
                       $signed(bus.out_data), bus.out_ch, sat,
                       $signed(e.d), e.ch, e.s);
            end
          end
        end
        prev_v = bus.out_valid;
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_ch     = '0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk) reset_n = 1'b1;
    #1;
    chk("rst_in_ready", int'(bus.in_ready), 1);
    chk("rst_out_valid", int'(bus.out_valid), 0);
    chk("rst_out_data", int'(bus.out_data), 0);
    chk("rst_out_ch", int'(bus.out_ch), 0);
    chk("rst_sat", int'(sat), 0);
    chk("rst_ch_err", int'(ch_err), 0);

    // impulse on ch0 with default bank
    expect_out(0, 991, 1'b0);
    issue(0, 1000);
    lat_check();
    expect_out(0, 3947, 1'b0);
    issue(0, 0);
    lat_check();

    // channel isolation; ch0 then continues its own response
    expect_out(1, 0, 1'b0);
    issue(1, 0);
    expect_out(0, 7842, 1'b0);
    issue(0, 0);

    // backpressure: 1015*500 >>> 10 = 495
    wait_ready();
    bus.out_ready = 1'b0;
    expect_out(1, 495, 1'b0);
    issue(1, 500);
    lat_check();
    repeat (10) begin
      @(negedge clk);
      chk("bp_valid", int'(bus.out_valid), 1);
      chk("bp_data", int'($signed(bus.out_data)), 495);
      chk("bp_ch", int'(bus.out_ch), 1);
      chk("bp_in_ready", int'(bus.in_ready), 0);
    end
    bus.out_ready = 1'b1;

    // illegal channel
    issue(3, 777);
    chk("ch_err_pulse", int'(ch_err), 1);
    chk("ch_err_idle", int'(bus.in_ready), 1);
    @(posedge clk);
    #1 chk("ch_err_clear", int'(ch_err), 0);
    repeat (10) @(negedge clk);
    chk("ch_err_no_out", int'(bus.out_valid), 0);

    // async reset while tap 2 is executing
    issue(0, 1234);
    repeat (2) @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("mid_rst_valid", int'(bus.out_valid), 0);
    chk("mid_rst_data", int'(bus.out_data), 0);
    repeat (2) @(posedge clk);
    @(negedge clk) reset_n = 1'b1;
    expect_out(0, 991, 1'b0);
    issue(0, 1000);
    lat_check();

    // saturation: 32479, then clip with sat pulse
    expect_out(1, 32479, 1'b0);
    issue(1, 32767);
    expect_out(1, 32767, 1'b1);
    issue(1, 32767);

    // commit during MAC: in-flight sample keeps the old bank
    expect_out(2, 991, 1'b0);
    issue(2, 1000);
    wcoef(0, 1024, 1'b0);
    wcoef(1, 0, 1'b0);
    wcoef(2, 0, 1'b0);
    wcoef(3, 0, 1'b0);
    wcoef(4, 0, 1'b1);
    expect_out(2, -1234, 1'b0);
    issue(2, -1234);

    // write+commit on one idle edge; output = y1 of ch1 (saturated)
    wait_ready();
    wcoef(0, 0, 1'b0);
    wcoef(5, 32767, 1'b0);
    wcoef(3, 1024, 1'b1);
    expect_out(1, 32767, 1'b0);
    issue(1, 5);

    wait_ready();
    repeat (3) @(negedge clk);
    chk("sb_empty", q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
